// File: rtl/alu_pkg.sv
// Shared op codes, FSM state and flag bundle for the bit-serial sliced ALU.
package alu_pkg;

   localparam logic       MODE_ARITH = 1'b0;
   localparam logic       MODE_LOGIC = 1'b1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_PASS = 3'b100;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOT  = 3'b011;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   typedef struct packed {
      logic c;
      logic z;
      logic s;
      logic v;
   } flags_t;

   // Carry fed into slice 0: SUB/INC need the +1, ADD takes the user carry.
   function automatic logic init_carry(input logic mode, input logic [2:0] op, input logic cin);
      logic w_c;
      w_c = 1'b0;
      if (mode == MODE_ARITH) begin
         case (op)
            OP_ADD:         w_c = cin;
            OP_SUB, OP_INC: w_c = 1'b1;
            default:        w_c = 1'b0;
         endcase
      end
      return w_c;
   endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; also exposes the carry into its MSB for overflow.
module alu_slice
   import alu_pkg::*;
#(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] i_a,
   input  logic [SLICE-1:0] i_b,
   input  logic             i_mode,
   input  logic [2:0]       i_op,
   input  logic             i_cin,
   output logic [SLICE-1:0] o_out,
   output logic             o_cout,
   output logic             o_msb_cin
);

   logic [SLICE-1:0] w_b_eff;
   logic [SLICE:0]   w_sum;

   always_comb begin
      w_b_eff   = '0;
      w_sum     = '0;
      o_out     = '0;
      o_cout    = 1'b0;
      o_msb_cin = 1'b0;
      if (i_mode == MODE_ARITH) begin
         // INC and PASS add zero; the +1 for INC arrives on the carry chain.
         case (i_op)
            OP_ADD:  w_b_eff = i_b;
            OP_SUB:  w_b_eff = ~i_b;
            OP_DEC:  w_b_eff = '1;
            default: w_b_eff = '0;
         endcase
         w_sum     = {1'b0, i_a} + {1'b0, w_b_eff} + {{SLICE{1'b0}}, i_cin};
         o_out     = w_sum[SLICE-1:0];
         o_cout    = w_sum[SLICE];
         o_msb_cin = i_a[SLICE-1] ^ w_b_eff[SLICE-1] ^ w_sum[SLICE-1];
      end else begin
         case (i_op)
            OP_AND:  o_out = i_a & i_b;
            OP_OR:   o_out = i_a | i_b;
            OP_XOR:  o_out = i_a ^ i_b;
            OP_NOT:  o_out = ~i_a;
            default: o_out = '0;
         endcase
      end
   end

endmodule

// File: rtl/sliced_alu.sv
// Multi-cycle ALU: processes SLICE bits per cycle, LSB slice first, valid/ready on both sides.
module sliced_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   input  logic [2:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             sign_flag,
   output logic             overflow_flag
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH % SLICE != 0) begin : g_bad_slice
         $error("sliced_alu: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a, r_b, r_result;
   logic             r_mode, r_carry, r_zacc;
   logic [2:0]       r_op;
   flags_t           r_flags;

   logic             w_last;
   int               w_base;
   logic [SLICE-1:0] w_out;
   logic             w_cout, w_msb_cin, w_arith, w_ovf_op;

   assign w_last   = (r_cnt == CW'(N - 1));
   assign w_base   = int'(r_cnt) * SLICE;
   assign w_arith  = (r_mode == MODE_ARITH);
   // ADD/SUB/INC/DEC occupy codes 0-3; PASS and its aliases have op[2] set.
   assign w_ovf_op = w_arith && !r_op[2];

   alu_slice #(.SLICE(SLICE)) u_slice (
      .i_a      (r_a[w_base +: SLICE]),
      .i_b      (r_b[w_base +: SLICE]),
      .i_mode   (r_mode),
      .i_op     (r_op),
      .i_cin    (r_carry),
      .o_out    (w_out),
      .o_cout   (w_cout),
      .o_msb_cin(w_msb_cin)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_next = ST_RUN;
         ST_RUN:  if (w_last)    w_next = ST_DONE;
         ST_DONE: if (out_ready) w_next = ST_IDLE;
         default:                w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_zacc   <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_mode   <= 1'b0;
         r_op     <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (in_valid) begin
               r_a     <= a;
               r_b     <= b;
               r_mode  <= mode;
               r_op    <= op;
               r_carry <= init_carry(mode, op, cin);
               r_cnt   <= '0;
               r_zacc  <= 1'b1;
            end
            ST_RUN: begin
               r_result[w_base +: SLICE] <= w_out;
               r_carry <= w_cout;
               r_zacc  <= r_zacc & ~|w_out;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_flags.c <= w_arith & w_cout;
                  r_flags.z <= r_zacc & ~|w_out;
                  r_flags.s <= w_out[SLICE-1];
                  r_flags.v <= w_ovf_op & (w_msb_cin ^ w_cout);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready      = (r_state == ST_IDLE);
   assign out_valid     = (r_state == ST_DONE);
   assign result        = r_result;
   assign carry_flag    = r_flags.c;
   assign zero_flag     = r_flags.z;
   assign sign_flag     = r_flags.s;
   assign overflow_flag = r_flags.v;

endmodule

// File: tb/tb_sliced_alu.sv
// Directed-vector bench: an 8-bit/4-slice and a 32-bit/1-slice instance, hand-computed expectations.
module tb_sliced_alu;

   logic        clk, reset, out_ready, mode, cin;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        iv8, ir8, ov8, c8, z8, s8, v8;
   logic [7:0]  res8;
   logic        iv32, ir32, ov32, c32, z32, s32, v32;
   logic [31:0] res32;

   int n_vec = 0;
   int n_err = 0;

   sliced_alu #(.WIDTH(8), .SLICE(4)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
      .a(a[7:0]), .b(b[7:0]), .mode(mode), .op(op), .cin(cin),
      .out_valid(ov8), .out_ready(out_ready), .result(res8),
      .carry_flag(c8), .zero_flag(z8), .sign_flag(s8), .overflow_flag(v8)
   );

   sliced_alu #(.WIDTH(32), .SLICE(1)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
      .a(a), .b(b), .mode(mode), .op(op), .cin(cin),
      .out_valid(ov32), .out_ready(out_ready), .result(res32),
      .carry_flag(c32), .zero_flag(z32), .sign_flag(s32), .overflow_flag(v32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Flags packed as {C,Z,S,V}.
   task automatic do_op(input bit wide, input logic m, input logic [2:0] o,
                        input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                        output logic [31:0] res, output logic [3:0] fl, output int lat);
      logic got;
      mode = m; op = o; a = aa; b = bb; cin = ci;
      if (wide) iv32 = 1'b1; else iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; iv32 = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         got = wide ? ov32 : ov8;
      end
      if (!got) chk("timeout", {31'b0, got}, 32'd1);
      res = wide ? res32 : {24'b0, res8};
      fl  = wide ? {c32, z32, s32, v32} : {c8, z8, s8, v8};
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic do_vec(input string name, input bit wide, input logic m, input logic [2:0] o,
                         input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                         input logic [31:0] exp_res, input logic [3:0] exp_fl);
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      do_op(wide, m, o, aa, bb, ci, res, fl, lat);
      chk({name, ".res"}, res, exp_res);
      chk({name, ".flags"}, {28'b0, fl}, {28'b0, exp_fl});
      chk({name, ".lat"}, lat, wide ? 32'd32 : 32'd2);
      chk({name, ".idle"}, {30'b0, (wide ? ir32 : ir8), (wide ? ov32 : ov8)}, 32'd2);
   endtask

   initial begin
      logic [7:0] cap_res;
      logic [3:0] cap_fl;
      int         wait_n;

      reset = 1'b1; out_ready = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
      mode = 1'b0; op = 3'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("rst.res8",  {24'b0, res8}, 32'h0);
      chk("rst.flag8", {28'b0, c8, z8, s8, v8}, 32'h0);
      chk("rst.hs8",   {30'b0, ir8, ov8}, 32'd2);
      chk("rst.hs32",  {30'b0, ir32, ov32}, 32'd2);

      //      name     wide mode  op      a             b             cin   result        CZSV
      do_vec("addff",  0, 1'b0, 3'b000, 32'hFF,       32'h01,       1'b0, 32'h00,       4'b1100);
      do_vec("sub80",  0, 1'b0, 3'b001, 32'h80,       32'h01,       1'b0, 32'h7F,       4'b1001);
      do_vec("xoraa",  0, 1'b1, 3'b010, 32'hAA,       32'hAA,       1'b0, 32'h00,       4'b0100);
      do_vec("not0f",  0, 1'b1, 3'b011, 32'h0F,       32'h33,       1'b0, 32'hF0,       4'b0010);
      do_vec("addci",  0, 1'b0, 3'b000, 32'h7F,       32'h00,       1'b1, 32'h80,       4'b0011);
      do_vec("addx",   0, 1'b0, 3'b000, 32'h0F,       32'h01,       1'b0, 32'h10,       4'b0000);
      do_vec("addv0",  0, 1'b0, 3'b000, 32'hA5,       32'h5A,       1'b1, 32'h00,       4'b1100);
      do_vec("subbw",  0, 1'b0, 3'b001, 32'h01,       32'h02,       1'b0, 32'hFF,       4'b0010);
      do_vec("subov",  0, 1'b0, 3'b001, 32'h7F,       32'hFF,       1'b0, 32'h80,       4'b0011);
      do_vec("incff",  0, 1'b0, 3'b010, 32'hFF,       32'h55,       1'b0, 32'h00,       4'b1100);
      do_vec("dec00",  0, 1'b0, 3'b011, 32'h00,       32'h00,       1'b0, 32'hFF,       4'b0010);
      do_vec("dec80",  0, 1'b0, 3'b011, 32'h80,       32'h00,       1'b0, 32'h7F,       4'b1001);
      do_vec("pass6",  0, 1'b0, 3'b110, 32'h5A,       32'hFF,       1'b1, 32'h5A,       4'b0000);
      do_vec("and",    0, 1'b1, 3'b000, 32'hF0,       32'h3C,       1'b0, 32'h30,       4'b0000);
      do_vec("or",     0, 1'b1, 3'b001, 32'h0F,       32'h30,       1'b0, 32'h3F,       4'b0000);
      do_vec("lop5",   0, 1'b1, 3'b101, 32'hFF,       32'hFF,       1'b0, 32'h00,       4'b0100);
      do_vec("w_add",  1, 1'b0, 3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0011);
      do_vec("w_sub",  1, 1'b0, 3'b001, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 4'b0010);

      // Back-pressure in DONE: output holds, new requests ignored.
      mode = 1'b0; op = 3'b000; a = 32'h12; b = 32'h34; cin = 1'b0;
      iv8 = 1'b1;
      @(posedge clk); #1 iv8 = 1'b0;
      wait_n = 0;
      while (!ov8 && wait_n < 20) begin @(posedge clk); #1 wait_n++; end
      chk("hold.valid", {31'b0, ov8}, 32'd1);
      cap_res = res8; cap_fl = {c8, z8, s8, v8};
      chk("hold.res0", {24'b0, cap_res}, 32'h46);
      iv8 = 1'b1; a = 32'h55; b = 32'hAA; op = 3'b001;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold.res",  {24'b0, res8}, {24'b0, cap_res});
         chk("hold.flag", {28'b0, c8, z8, s8, v8}, {28'b0, cap_fl});
         chk("hold.hs",   {30'b0, ir8, ov8}, 32'd1);
      end
      iv8 = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("hold.rel", {30'b0, ir8, ov8}, 32'd2);
      repeat (3) @(posedge clk);
      #1 chk("hold.noacc", {30'b0, ir8, ov8}, 32'd2);

      // Reset in the middle of RUN aborts cleanly.
      mode = 1'b0; op = 3'b000; a = 32'hFF; b = 32'hFF; cin = 1'b1;
      iv8 = 1'b1;
      @(posedge clk); #1 iv8 = 1'b0;
      chk("abort.run", {31'b0, ir8}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("abort.hs",   {30'b0, ir8, ov8}, 32'd2);
      chk("abort.res",  {24'b0, res8}, 32'h0);
      chk("abort.flag", {28'b0, c8, z8, s8, v8}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort.nopulse", {31'b0, ov8}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sliced_alu.md
SLICED_ALU -- requirements
Module: sliced_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4: bits processed per cycle; WIDTH % SLICE == 0 checked at elaboration; N = WIDTH/SLICE.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  operands/op presented.
REQ-007 SHALL have port in_ready  output  1  block can accept an operation.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port mode  input  1  0 = arithmetic, 1 = logic.
REQ-011 SHALL have port op  input  3  operation select.
REQ-012 SHALL have port cin  input  1  carry-in, used by ADD only.
REQ-013 SHALL have port out_valid  output  1  result and flags valid.
REQ-014 SHALL have port out_ready  input  1  consumer takes the result.
REQ-015 SHALL have port result  output  WIDTH  operation result.
REQ-016 SHALL have ports carry_flag, zero_flag, sign_flag, overflow_flag  output  1 each  status flags.

Function
REQ-017 Arithmetic ops (mode=0) SHALL be: 000 ADD a+b+cin; 001 SUB a+~b+1; 010 INC a+1; 011 DEC a+all-ones; 100 PASS a. Codes 101-111 SHALL behave as PASS.
REQ-018 Logic ops (mode=1) SHALL be: 000 AND; 001 OR; 010 XOR; 011 NOT a. Codes 100-111 SHALL yield 0.
REQ-019 FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-020 In IDLE, if in_valid, SHALL latch a, b, mode, op, and initial carry (cin for ADD, 1 for SUB/INC, 0 otherwise), clear slice counter, and enter RUN.
REQ-021 In RUN, each cycle SHALL compute slice k (bits k*SLICE+SLICE-1 .. k*SLICE, LSB slice first), write those result bits, and register the slice carry-out as the next carry-in.
REQ-022 After slice N-1, SHALL enter DONE; out_valid = 1 exactly in DONE; an accept at edge t gives out_valid high from edge t+N.
REQ-023 In DONE, result and flags SHALL hold stable until out_valid && out_ready, after which the FSM returns to IDLE at that edge.
REQ-024 carry_flag SHALL be the final-slice carry-out for arithmetic ops; SUB carry = 1 means no borrow; logic ops SHALL give carry 0.
REQ-025 overflow_flag SHALL be carry-into-MSB XOR carry-out-of-MSB for ADD/SUB/INC/DEC; 0 for PASS and logic ops.
REQ-026 zero_flag SHALL be 1 iff all WIDTH result bits are 0, accumulated across slices; sign_flag SHALL equal result[WIDTH-1].
REQ-027 in_valid SHALL be ignored outside IDLE; inputs sampled only at the accepting edge.
REQ-028 With SLICE = WIDTH (N=1), SHALL take exactly one RUN cycle.

Reset
REQ-029 On reset SHALL enter IDLE, clear counter and carry, and drive result = 0, all flags = 0, out_valid = 0, in_ready = 1 after the edge.
REQ-030 Reset in RUN or DONE SHALL abort the operation with no out_valid pulse; reset SHALL take priority over all handshakes.

Structure
REQ-031 Shared package alu_pkg SHALL hold the op code constants, the state enum, and the flag struct.
REQ-032 SHALL instantiate one sub-module alu_slice (SLICE-bit combinational slice: a, b, mode, op, cin -> out, cout, msb carry-in).

Verification
REQ-033 WIDTH=8, SLICE=4: ADD a=0xFF b=0x01 cin=0 -> result 0x00, C=1 Z=1 S=0 V=0, out_valid 2 cycles after accept.
REQ-034 SUB a=0x80 b=0x01 -> result 0x7F, C=1 Z=0 S=0 V=1.
REQ-035 Logic XOR a=0xAA b=0xAA -> 0x00, Z=1 C=0 V=0; NOT a=0x0F -> 0xF0, S=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result/flags constant, in_ready=0, new in_valid ignored.
REQ-037 Assert reset during RUN -> next cycle IDLE, out_valid=0, result=0, in_ready=1.
REQ-038 WIDTH=32, SLICE=1: ADD 0x7FFFFFFF+1 -> 0x80000000, V=1 S=1, out_valid 32 cycles after accept.
